// File: rtl/data_mem_responder.sv
// Data-memory endpoint for the control_unit load/store interface: word-organised
// little-endian RAM with lane-masked stores, extended loads and a latency-timed response.
package data_mem_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;
endpackage

module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  mem_size_e   mem_size,
  input  logic        mem_usign_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // BUSY  | access done, latency down-counter running
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   ram [DEPTH_WORDS];

  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic          store_en;
  logic [AW-1:0] word_idx;
  logic [31:0]   word_rd;
  logic [31:0]   load_ext;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    lane_we;
  logic [31:0]   lane_data;

  assign accept       = req_valid && req_ready;
  assign word_idx     = addr[AW+1:2];
  assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  assign word_rd      = ram[word_idx];

  // Unencoded size value 2'b11 is rejected like a misaligned access.
  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = addr[0];
      MEM_WORD: misaligned = |addr[1:0];
      default:  misaligned = 1'b1;
    endcase
  end

  // A no-op never reports an error, whatever its address.
  assign req_err  = (mem_read && mem_write) ||
                    ((mem_read || mem_write) && (misaligned || out_of_range));
  assign store_en = accept && mem_write && !req_err;

  always_comb begin
    lane_we   = 4'b0000;
    lane_data = wdata;
    case (mem_size)
      MEM_BYTE: begin
        lane_we[addr[1:0]] = 1'b1;
        lane_data          = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        lane_we   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: lane_we = 4'b1111;
    endcase
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_we[i]) ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    byte_sel = word_rd[{addr[1:0], 3'b000} +: 8];
    half_sel = addr[1] ? word_rd[31:16] : word_rd[15:0];
    load_ext = word_rd;
    case (mem_size)
      MEM_BYTE: load_ext = mem_usign_load ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: load_ext = mem_usign_load ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  load_ext = word_rd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      rsp_err <= req_err;
      rdata   <= (mem_read && !req_err) ? load_ext : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= CW'(LATENCY - 1);
    else if (state == BUSY) cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP);
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: one responder with LATENCY=1 (index 0) and one with LATENCY=3 (index 1).
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int DEPTH = 64;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid      [2];
  logic        req_ready      [2];
  logic        mem_read       [2];
  logic        mem_write      [2];
  mem_size_e   mem_size       [2];
  logic        mem_usign_load [2];
  logic [31:0] addr           [2];
  logic [31:0] wdata          [2];
  logic        rsp_valid      [2];
  logic        rsp_ready      [2];
  logic [31:0] rdata          [2];
  logic        rsp_err        [2];

  int   checks   = 0;
  int   failures = 0;
  int   lat_exp [2] = '{1, 3};
  exp_t sb_q [$];
  exp_t mon_e;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_size(mem_size[0]),
    .mem_usign_load(mem_usign_load[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rdata(rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_size(mem_size[1]),
    .mem_usign_load(mem_usign_load[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rdata(rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Monitor: compares every response taken by the consumer against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && rsp_valid[d] && rsp_ready[d]) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp dut%0d actual=response required=none", d);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_dut"}, 32'(d), 32'(mon_e.d));
          check({mon_e.name, "_rdata"}, rdata[d], mon_e.rdata);
          check1({mon_e.name, "_err"}, rsp_err[d], mon_e.err);
        end
      end
    end
  end

  task automatic present(input int d, input logic rd, input logic wr, input mem_size_e sz,
                         input logic us, input logic [31:0] a, input logic [31:0] wd);
    mem_read[d]       = rd;
    mem_write[d]      = wr;
    mem_size[d]       = sz;
    mem_usign_load[d] = us;
    addr[d]           = a;
    wdata[d]          = wd;
  endtask

  task automatic push_exp(input int d, input logic [31:0] er, input logic ee, input string nm);
    exp_t e;
    e.d = d; e.rdata = er; e.err = ee; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Full request with rsp_ready high; checks acceptance, latency and req_ready return.
  task automatic issue(input int d, input logic rd, input logic wr, input mem_size_e sz,
                       input logic us, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input string nm);
    int n;
    present(d, rd, wr, sz, us, a, wd);
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(posedge clk); #1; n++; end
    check1({nm, "_accept"}, req_ready[d], 1'b1);
    if (req_ready[d]) begin
      push_exp(d, er, ee, nm);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      n = 1;
      while (!rsp_valid[d] && n < 20) begin @(posedge clk); #1; n++; end
      check({nm, "_latency"}, 32'(n), 32'(lat_exp[d]));
      if (rsp_valid[d]) begin
        @(posedge clk); #1;
        check1({nm, "_ready_after"}, req_ready[d], 1'b1);
      end else begin
        void'(sb_q.pop_back());
      end
    end else begin
      req_valid[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      present(d, 1'b0, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0);
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      check1("rst_req_ready", req_ready[d], 1'b0);
      check1("rst_rsp_valid", rsp_valid[d], 1'b0);
      check("rst_rdata", rdata[d], 32'h0);
      check1("rst_rsp_err", rsp_err[d], 1'b0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: basic store/load, extension, lane masking, errors, boundaries
    issue(0, 0, 1, MEM_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, "sw_10");
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'hDEADBEEF, 0, "lw_10");
    issue(0, 1, 0, MEM_WORD, 1, 32'h10, 32'h0,       32'hDEADBEEF, 0, "lw_usign_ignored");
    issue(0, 1, 0, MEM_BYTE, 0, 32'h13, 32'h0,       32'hFFFFFFDE, 0, "lb_13");
    issue(0, 1, 0, MEM_BYTE, 1, 32'h13, 32'h0,       32'h000000DE, 0, "lbu_13");
    issue(0, 1, 0, MEM_BYTE, 0, 32'h10, 32'h0,       32'hFFFFFFEF, 0, "lb_10");
    issue(0, 1, 0, MEM_BYTE, 1, 32'h11, 32'h0,       32'h000000BE, 0, "lbu_11");
    issue(0, 1, 0, MEM_HALF, 0, 32'h12, 32'h0,       32'hFFFFDEAD, 0, "lh_12");
    issue(0, 1, 0, MEM_HALF, 1, 32'h10, 32'h0,       32'h0000BEEF, 0, "lhu_10");
    issue(0, 1, 0, MEM_HALF, 0, 32'h10, 32'h0,       32'hFFFFBEEF, 0, "lh_10");
    issue(0, 0, 1, MEM_BYTE, 0, 32'h11, 32'hAAAAAA55, 32'h0,       0, "sb_11");
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'hDEAD55EF, 0, "lw_after_sb");
    issue(0, 0, 1, MEM_HALF, 0, 32'h12, 32'hFFFF1234, 32'h0,       0, "sh_12");
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'h123455EF, 0, "lw_after_sh");
    issue(0, 1, 0, MEM_WORD, 0, 32'h12, 32'h0,       32'h0,        1, "lw_misaligned");
    issue(0, 0, 1, MEM_HALF, 0, 32'h11, 32'h0000FFFF, 32'h0,       1, "sh_misaligned");
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'h123455EF, 0, "lw_after_bad_sh");
    issue(0, 1, 0, MEM_HALF, 0, 32'h13, 32'h0,       32'h0,        1, "lh_misaligned");
    issue(0, 1, 0, MEM_WORD, 0, 4*DEPTH,  32'h0,     32'h0,        1, "lw_out_of_range");
    issue(0, 1, 0, MEM_WORD, 0, 32'h80000010, 32'h0, 32'h0,        1, "lw_high_addr");
    issue(0, 1, 1, MEM_WORD, 0, 32'h10, 32'h77777777, 32'h0,       1, "rd_and_wr");
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'h123455EF, 0, "lw_after_rdwr");
    issue(0, 0, 0, MEM_WORD, 0, 32'h10, 32'h0,       32'h0,        0, "noop");
    issue(0, 0, 1, MEM_WORD, 0, 4*DEPTH-4, 32'h89ABCDEF, 32'h0,    0, "sw_last");
    issue(0, 1, 0, MEM_WORD, 0, 4*DEPTH-4, 32'h0,    32'h89ABCDEF, 0, "lw_last");
    issue(0, 1, 0, MEM_HALF, 0, 4*DEPTH-2, 32'h0,    32'hFFFF89AB, 0, "lh_last");
    issue(0, 1, 0, MEM_BYTE, 1, 4*DEPTH-1, 32'h0,    32'h00000089, 0, "lbu_last");

    // LATENCY=3: backpressure with a competing request
    issue(1, 0, 1, MEM_WORD, 0, 32'h8, 32'h0BADF00D, 32'h0,        0, "l3_sw_8");
    rsp_ready[1] = 1'b0;
    present(1, 1, 0, MEM_WORD, 0, 32'h8, 32'h0);
    check1("bp_ready_before", req_ready[1], 1'b1);
    req_valid[1] = 1'b1;
    push_exp(1, 32'h0BADF00D, 1'b0, "bp_lw");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 1;
    while (!rsp_valid[1] && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_latency", 32'(n), 32'd3);
    present(1, 0, 1, MEM_WORD, 0, 32'h8, 32'h11111111);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check1("bp_valid_held", rsp_valid[1], 1'b1);
      check1("bp_req_ready_low", req_ready[1], 1'b0);
      check("bp_rdata_stable", rdata[1], 32'h0BADF00D);
      check1("bp_err_stable", rsp_err[1], 1'b0);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    check1("bp_ready_after", req_ready[1], 1'b1);
    check1("bp_valid_dropped", rsp_valid[1], 1'b0);
    issue(1, 1, 0, MEM_WORD, 0, 32'h8, 32'h0,       32'h0BADF00D, 0, "bp_no_compete");
    issue(1, 1, 0, MEM_BYTE, 0, 32'h9, 32'h0,       32'hFFFFFFF0, 0, "l3_lb_9");

    // Reset during BUSY: accepted store stays committed, response is dropped
    present(1, 0, 1, MEM_WORD, 0, 32'h20, 32'hCAFEF00D);
    check1("rb_ready_before", req_ready[1], 1'b1);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check1("rb_busy_no_valid", rsp_valid[1], 1'b0);
    check1("rb_busy_not_ready", req_ready[1], 1'b0);
    #2 rst = 1'b1;
    #1;
    check1("rb_rst_valid", rsp_valid[1], 1'b0);
    check1("rb_rst_ready", req_ready[1], 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check1("rb_ready_after_rst", req_ready[1], 1'b1);
    check1("rb_valid_after_rst", rsp_valid[1], 1'b0);
    issue(1, 1, 0, MEM_WORD, 0, 32'h20, 32'h0,      32'hCAFEF00D, 0, "rb_lw_20");

    // Reset during RESP: rsp_valid and rdata drop without a clock edge
    rsp_ready[1] = 1'b0;
    present(1, 1, 0, MEM_WORD, 0, 32'h20, 32'h0);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    n = 1;
    while (!rsp_valid[1] && n < 20) begin @(posedge clk); #1; n++; end
    check1("rr_valid_before_rst", rsp_valid[1], 1'b1);
    check("rr_rdata_before_rst", rdata[1], 32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    check1("rr_rst_valid", rsp_valid[1], 1'b0);
    check("rr_rst_rdata", rdata[1], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    check1("rr_ready_after_rst", req_ready[1], 1'b1);
    issue(0, 1, 0, MEM_WORD, 0, 32'h10, 32'h0,      32'h123455EF, 0, "ram_kept_over_rst");

    repeat (2) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
